// File: rtl/and4_bist_pkg.sv
// Shared types and constants for the and4_bist self-test engine.
package and4_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    function automatic int vec_count(input int width);
        return 2 ** (2 * width);
    endfunction

    function automatic int sat_max(input int err_w);
        return (2 ** err_w) - 1;
    endfunction

    localparam int VEC_COUNT   = vec_count(4);
    localparam int ERR_SAT_MAX = sat_max(9);

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating mismatch counter: clear has priority over inc, holds at all-ones.
module bist_sat_counter
    import and4_bist_pkg::*;
#(
    parameter int ERR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    localparam logic [ERR_W-1:0] MAX_COUNT = ERR_W'(sat_max(ERR_W));

    logic [ERR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/and4_bist.sv
// Exhaustive self-test engine for a WIDTH-bit AND slice.
// Optional build macro AND4_BIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module and4_bist
    import and4_bist_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y
);

    localparam int IDX_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(vec_count(WIDTH) - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam state_t AFTER_DRIVE = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_y_q, fail_y_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             cnt_clear, cnt_inc, mismatch, err_zero;
    logic [ERR_W-1:0] err_cnt;

    assign mismatch = (dut_y != (dut_a_q & dut_b_q));
    assign err_zero = (err_cnt == '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        dut_a_d   = dut_a_q;
        dut_b_d   = dut_b_q;
        fail_a_d  = fail_a_q;
        fail_b_d  = fail_b_q;
        fail_y_d  = fail_y_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            // The accepting edge also drives vector 0, so a run is exactly
            // vectors * (2 + SETTLE_CYCLES) cycles long.
            IDLE, DONE: begin
                if (start) begin
                    idx_d     = '0;
                    dut_a_d   = '0;
                    dut_b_d   = '0;
                    fail_a_d  = '0;
                    fail_b_d  = '0;
                    fail_y_d  = '0;
                    settle_d  = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = AFTER_DRIVE;
                end
            end
            DRIVE: begin
                dut_a_d  = idx_q[WIDTH-1:0];
                dut_b_d  = idx_q[IDX_W-1:WIDTH];
                settle_d = '0;
                state_d  = AFTER_DRIVE;
            end
            SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_inc = mismatch;
                if (mismatch && err_zero) begin
                    fail_a_d = dut_a_q;
                    fail_b_d = dut_b_q;
                    fail_y_d = dut_y;
                end
`ifdef AND4_BIST_STOP_ON_FAIL_EN
                if (mismatch || (idx_q == IDX_LAST)) begin
`else
                if (idx_q == IDX_LAST) begin
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = err_zero && !mismatch;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            dut_a_q  <= '0;
            dut_b_q  <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            fail_y_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            dut_a_q  <= dut_a_d;
            dut_b_q  <= dut_b_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
            fail_y_q <= fail_y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    bist_sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (err_cnt)
    );

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_cnt;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_y    = fail_y_q;

endmodule

// File: tb/tb_and4_bist.sv
// Directed bench for and4_bist: a 9-bit and a 4-bit error-counter instance
// share one start/reset and each drive their own faultable AND4 model.
module tb_and4_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    int         fault = 0;
    int         checks = 0;
    int         errors = 0;
    int         cyc;

    logic [3:0] a9, b9, y9, fa9, fb9, fy9;
    logic       busy9, done9, pass9;
    logic [8:0] err9;
    logic [3:0] a4, b4, y4, fa4, fb4, fy4;
    logic       busy4, done4, pass4;
    logic [3:0] err4;

    always #5 clk = ~clk;

    // fault 1: y[3] stuck-at-0; fault 2: y[0] stuck-at-1
    function automatic logic [3:0] and_model(input logic [3:0] a, input logic [3:0] b, input int f);
        logic [3:0] y;
        y = a & b;
        if (f == 1) y[3] = 1'b0;
        if (f == 2) y[0] = 1'b1;
        return y;
    endfunction

    always_comb y9 = and_model(a9, b9, fault);
    always_comb y4 = and_model(a4, b4, fault);

    and4_bist #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_W(9)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a9), .dut_b(b9), .dut_y(y9),
        .busy(busy9), .done(done9), .pass(pass9), .err_count(err9),
        .fail_a(fa9), .fail_b(fb9), .fail_y(fy9)
    );

    and4_bist #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a4), .dut_b(b4), .dut_y(y4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .fail_a(fa4), .fail_b(fb4), .fail_y(fy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the negedge after the accepting edge (cycle 1).
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Counts edges until done is seen; poke re-asserts start mid-run.
    task automatic wait_done(input int poke, output int cycles);
        cycles = 1;
        while (!done9 && cycles < 3000) begin
            start = (cycles == poke);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy9, 0);
        check("rst_done", done9, 0);
        check("rst_pass", pass9, 0);
        check("rst_err", err9, 0);
        check("rst_dut_ab", {a9, b9}, 0);
        check("rst_fail", {fa9, fb9, fy9}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean AND model
        fault = 0;
        pulse_start();
        check("t1_busy", busy9, 1);
        wait_done(-1, cyc);
        check("t1_cycles", cyc, 768);
        check("t1_done", done9, 1);
        check("t1_busy_end", busy9, 0);
        check("t1_pass", pass9, 1);
        check("t1_err", err9, 0);
        check("t1_fail", {fa9, fb9, fy9}, 0);
        check("t1_dut_hold", {a9, b9}, 8'hFF);

        // y[3] stuck-at-0
        fault = 1;
        pulse_start();
        check("t2_done_clr", done9, 0);
        wait_done(-1, cyc);
`ifdef AND4_BIST_STOP_ON_FAIL_EN
        check("t6_cycles", cyc, 411);
        check("t6_err", err9, 1);
`else
        check("t2_cycles", cyc, 768);
        check("t2_err", err9, 64);
`endif
        check("t2_pass", pass9, 0);
        check("t2_fail_a", fa9, 4'h8);
        check("t2_fail_b", fb9, 4'h8);
        check("t2_fail_y", fy9, 4'h0);

        // y[0] stuck-at-1 on both instances
        fault = 2;
        pulse_start();
        wait_done(-1, cyc);
`ifdef AND4_BIST_STOP_ON_FAIL_EN
        check("t3_cycles", cyc, 3);
        check("t3_err4", err4, 1);
        check("t3_err9", err9, 1);
`else
        check("t3_err4_sat", err4, 15);
        check("t3_err9", err9, 192);
`endif
        check("t3_pass4", pass4, 0);
        check("t3_done4", done4, 1);
        check("t3_fail4", {fa4, fb4, fy4}, 12'h001);

        // Restart from DONE clears err, start mid-run ignored
        fault = 0;
        pulse_start();
        check("t5_done_drop", done9, 0);
        check("t5_busy", busy9, 1);
        check("t5_err_clr", err9, 0);
        check("t5_fail_clr", {fa9, fb9, fy9}, 0);
        wait_done(100, cyc);
        check("t5_cycles", cyc, 768);
        check("t5_pass", pass9, 1);

        // Reset at cycle 300 aborts the run
        pulse_start();
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_busy", busy9, 0);
        check("t4_rst_done", done9, 0);
        check("t4_rst_ab", {a9, b9}, 0);
        check("t4_rst_err", err9, 0);
        repeat (5) @(negedge clk);
        check("t4_idle_busy", busy9, 0);
        check("t4_idle_done", done9, 0);
        pulse_start();
        wait_done(-1, cyc);
        check("t4_cycles", cyc, 768);
        check("t4_pass", pass9, 1);
        check("t4_err", err9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
